// File: rtl/register_bank_sb.sv
//============================================================================
// Module   : register_bank_sb
// Brief    : Decode-stage register bank with two combinational read ports,
//            a dedicated PC port, optional write bypass and a busy scoreboard.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module register_bank_sb #(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int AW     = 3,
    parameter int PC_IDX = 7,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic             equal,
    output logic             busy1,
    output logic             busy2,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pc_wr_en,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    input  logic             flush
);

    localparam logic [AW-1:0] c_pcAddr = AW'(PC_IDX);

    logic [WIDTH-1:0] r_regFile [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busyNext;

    // General write is applied after the PC write so it wins on a PC_IDX conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regFile[i] <= '0;
            end
        end else begin
            if (pc_wr_en) begin
                r_regFile[PC_IDX] <= pc_in;
            end
            if (wr_en) begin
                r_regFile[wr_addr] <= wr_data;
            end
        end
    end

    // A newly issued producer outranks a same-cycle writeback to its destination.
    always_comb begin
        w_busyNext = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            if (flush) begin
                w_busyNext[i] = 1'b0;
            end else if (issue_en && (issue_addr == AW'(i))) begin
                w_busyNext[i] = 1'b1;
            end else if (wr_en && (wr_addr == AW'(i))) begin
                w_busyNext[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            logic w_wrHit1;
            logic w_wrHit2;
            logic w_pcHit1;
            logic w_pcHit2;

            assign w_wrHit1 = wr_en && (wr_addr == rd_addr1);
            assign w_wrHit2 = wr_en && (wr_addr == rd_addr2);
            assign w_pcHit1 = pc_wr_en && (rd_addr1 == c_pcAddr);
            assign w_pcHit2 = pc_wr_en && (rd_addr2 == c_pcAddr);

            assign rd_data1 = w_wrHit1 ? wr_data :
                              w_pcHit1 ? pc_in   : r_regFile[rd_addr1];
            assign rd_data2 = w_wrHit2 ? wr_data :
                              w_pcHit2 ? pc_in   : r_regFile[rd_addr2];

            // A value being forwarded this cycle is already available.
            assign busy1 = r_busy[rd_addr1] && !w_wrHit1;
            assign busy2 = r_busy[rd_addr2] && !w_wrHit2;
        end else begin : g_noBypass
            assign rd_data1 = r_regFile[rd_addr1];
            assign rd_data2 = r_regFile[rd_addr2];
            assign busy1    = r_busy[rd_addr1];
            assign busy2    = r_busy[rd_addr2];
        end
    endgenerate

    assign equal  = (rd_data1 == rd_data2);
    assign pc_out = r_regFile[PC_IDX];

endmodule

`default_nettype wire

// File: tb/tb_register_bank_sb.sv
//============================================================================
// Module   : tb_register_bank_sb
// Brief    : Directed bench driving a bypassed and a non-bypassed bank in parallel.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module tb_register_bank_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rd_addr1, rd_addr2, wr_addr, issue_addr;
    logic [15:0] wr_data, pc_in;
    logic        wr_en, pc_wr_en, issue_en, flush;

    logic [15:0] b_rd1, b_rd2, b_pc, n_rd1, n_rd2, n_pc;
    logic        b_eq, b_busy1, b_busy2, n_eq, n_busy1, n_busy2;

    int tests  = 0;
    int failed = 0;

    always #10 clk = ~clk;

    register_bank_sb #(.WIDTH(16), .NREGS(8), .AW(3), .PC_IDX(7), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b_rd1), .rd_data2(b_rd2), .equal(b_eq),
        .busy1(b_busy1), .busy2(b_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pc_wr_en(pc_wr_en), .pc_in(pc_in), .pc_out(b_pc),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush)
    );

    register_bank_sb #(.WIDTH(16), .NREGS(8), .AW(3), .PC_IDX(7), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(n_rd1), .rd_data2(n_rd2), .equal(n_eq),
        .busy1(n_busy1), .busy2(n_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pc_wr_en(pc_wr_en), .pc_in(pc_in), .pc_out(n_pc),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en = 0; pc_wr_en = 0; issue_en = 0; flush = 0;
    endtask

    initial begin
        reset = 0; idle();
        rd_addr1 = 0; rd_addr2 = 0; wr_addr = 0; issue_addr = 0;
        wr_data = 0; pc_in = 0;
        #1;
        check("rst_rd1",   b_rd1,   16'h0000);
        check("rst_pc",    b_pc,    16'h0000);
        check("rst_eq",    {15'd0, b_eq},    16'd1);
        check("rst_busy1", {15'd0, b_busy1}, 16'd0);

        // writes while reset is held are ignored
        wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF;
        tick();
        idle(); rd_addr1 = 3; #1;
        check("rst_hold_wr", n_rd1, 16'h0000);
        reset = 1;

        // R3 <- BEEF, then mark R3 busy
        tick();
        wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF;
        tick();
        idle(); issue_en = 1; issue_addr = 3;
        tick();
        idle(); #1;
        check("r3_val",  n_rd1, 16'hBEEF);
        check("r3_busy", {15'd0, n_busy1}, 16'd1);

        // asynchronous reset, observed without a clock edge
        reset = 0; #1;
        check("arst_rd1",   b_rd1, 16'h0000);
        check("arst_pc",    b_pc,  16'h0000);
        check("arst_busy1", {15'd0, b_busy1}, 16'd0);
        check("arst_eq",    {15'd0, b_eq},    16'd1);
        tick();
        reset = 1;
        tick();

        // bypass of a general write
        wr_en = 1; wr_addr = 2; wr_data = 16'h1234; rd_addr1 = 2; #1;
        check("byp_rd1",   b_rd1, 16'h1234);
        check("nobyp_old", n_rd1, 16'h0000);
        tick();
        idle(); #1;
        check("nobyp_new", n_rd1, 16'h1234);

        // PC conflict: general write wins
        wr_en = 1; wr_addr = 7; wr_data = 16'h0040;
        pc_wr_en = 1; pc_in = 16'h0011; rd_addr2 = 7; #1;
        check("pc_before",   b_pc,  16'h0000);
        check("pc_byp_prio", b_rd2, 16'h0040);
        tick();
        idle(); #1;
        check("pc_conflict", b_pc, 16'h0040);
        pc_wr_en = 1; pc_in = 16'h0011; #1;
        check("pc_byp_in", b_rd2, 16'h0011);
        check("pc_nobyp",  n_rd2, 16'h0040);
        tick();
        idle(); #1;
        check("pc_only",     b_pc, 16'h0011);
        check("pc_only_nob", n_pc, 16'h0011);

        // equality flag
        wr_en = 1; wr_addr = 1; wr_data = 16'h00FF;
        tick();
        wr_addr = 4;
        tick();
        idle(); rd_addr1 = 1; rd_addr2 = 4; #1;
        check("eq_same", {15'd0, b_eq}, 16'd1);
        wr_en = 1; wr_addr = 4; wr_data = 16'h00FE; #1;
        check("eq_byp",   {15'd0, b_eq}, 16'd0);
        check("eq_nobyp", {15'd0, n_eq}, 16'd1);
        tick();
        idle(); #1;
        check("eq_after", {15'd0, n_eq}, 16'd0);

        // scoreboard set / hold / clear
        issue_en = 1; issue_addr = 5; rd_addr1 = 5; #1;
        check("sb_issue_same", {15'd0, b_busy1}, 16'd0);
        tick();
        idle(); #1;
        check("sb_set", {15'd0, b_busy1}, 16'd1);
        wr_en = 1; wr_addr = 5; wr_data = 16'h5555; issue_en = 1; issue_addr = 5; #1;
        check("sb_fwd_byp",  {15'd0, b_busy1}, 16'd0);
        check("sb_fwd_nob",  {15'd0, n_busy1}, 16'd1);
        tick();
        idle(); #1;
        check("sb_reissue", {15'd0, b_busy1}, 16'd1);
        wr_en = 1; wr_addr = 5; wr_data = 16'h6666; #1;
        check("sb_wb_byp", {15'd0, b_busy1}, 16'd0);
        check("sb_wb_nob", {15'd0, n_busy1}, 16'd1);
        tick();
        idle(); #1;
        check("sb_clear", {15'd0, n_busy1}, 16'd0);

        // PC writes leave busy bits alone
        issue_en = 1; issue_addr = 7;
        tick();
        idle(); pc_wr_en = 1; pc_in = 16'h0022;
        tick();
        idle(); rd_addr2 = 7; #1;
        check("sb_pc_hold", {15'd0, b_busy2}, 16'd1);

        // flush beats a same-cycle issue
        issue_en = 1; issue_addr = 1;
        tick();
        issue_addr = 2;
        tick();
        issue_addr = 3;
        tick();
        idle(); rd_addr1 = 1; rd_addr2 = 3; #1;
        check("fl_pre1", {15'd0, b_busy1}, 16'd1);
        check("fl_pre3", {15'd0, b_busy2}, 16'd1);
        flush = 1; issue_en = 1; issue_addr = 6;
        tick();
        idle(); #1;
        check("fl_r1", {15'd0, b_busy1}, 16'd0);
        check("fl_r3", {15'd0, b_busy2}, 16'd0);
        rd_addr1 = 6; rd_addr2 = 2; #1;
        check("fl_r6", {15'd0, b_busy1}, 16'd0);
        check("fl_r2", {15'd0, b_busy2}, 16'd0);
        rd_addr1 = 7; #1;
        check("fl_r7", {15'd0, n_busy1}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register_bank_sb.md
# register_bank_sb

Parametrised general-purpose register bank for the pipelined RISC15 core, with a configurable number of registers and data width and two combinational read ports. It also provides a dedicated program-counter register port, optional same-cycle write-to-read bypass, and an operand equality flag for branch resolution. A per-register busy scoreboard lets the decode stage detect read-after-write hazards. It sits in the decode stage, and writeback drives its write port.

## Interface
- WIDTH, 16, data width of every register
- NREGS, 8, number of registers; must be a power of two ≥ 2
- AW, 3, address width; must equal log2(NREGS)
- PC_IDX, 7, index of the register that also serves as the program counter
- BYPASS, 1, 1 = write data forwarded to read ports in the same cycle; 0 = no forwarding

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- rd_addr1, rd_addr2  in  AW  read addresses
- rd_data1, rd_data2  out  WIDTH  read data; combinational
- equal  out  1  high when rd_data1 == rd_data2
- busy1, busy2  out  1  scoreboard status of rd_addr1 / rd_addr2
- wr_en  in  1  general write enable (writeback)
- wr_addr  in  AW  general write address
- wr_data  in  WIDTH  general write data
- pc_wr_en  in  1  dedicated PC write enable
- pc_in  in  WIDTH  dedicated PC write data
- pc_out  out  WIDTH  registered contents of register PC_IDX; never bypassed
- issue_en  in  1  marks register issue_addr busy (an instruction targeting it was issued)
- issue_addr  in  AW  destination of the issued instruction
- flush  in  1  clears all busy bits (pipeline flush)

## Operation
- Storage: NREGS × WIDTH flops, plus NREGS busy flops.
- Reset (reset = 0, asynchronous):
  - all registers and busy bits clear to 0 immediately;
  - so rd_data1/2 = 0, pc_out = 0, equal = 1, busy1/2 = 0;
  - writes, issue and flush are ignored while reset is held.
- General write: on the edge with wr_en = 1, reg[wr_addr] ← wr_data.
- PC write: on the edge with pc_wr_en = 1, reg[PC_IDX] ← pc_in.
- Conflict: if wr_en = 1, wr_addr = PC_IDX and pc_wr_en = 1, the general write wins and pc_in is dropped.
- Read, BYPASS = 1, for each port, in priority order:
  - wr_en && wr_addr == rd_addr → wr_data;
  - else pc_wr_en && rd_addr == PC_IDX → pc_in;
  - else stored value.
- Read, BYPASS = 0: always the stored value.
- equal compares the post-bypass read values over the full WIDTH.
- Scoreboard, next busy[i], in priority order:
  - flush → 0 for all i;
  - issue_en && issue_addr == i → 1 (a new producer wins over a same-cycle writeback to the same register);
  - wr_en && wr_addr == i → 0;
  - otherwise hold.
- pc_wr_en never affects busy bits.
- busy outputs:
  - BYPASS = 1: busyN = busy[rd_addrN] && !(wr_en && wr_addr == rd_addrN). The value is being forwarded this cycle, so it is not reported busy.
  - BYPASS = 0: busyN = busy[rd_addrN].
  - Same-cycle issue_en does not affect busyN until the next cycle.
- No register is hardwired to zero.

## Timing
- Read latency: 0 cycles (combinational from address and stored state).
- Write-to-read latency: 0 cycles with BYPASS = 1; 1 cycle with BYPASS = 0.
- pc_out changes only on the edge after a PC or general write to PC_IDX.
- Busy set and clear take effect on the edge; they become visible on busyN in the following cycle.
- Reset assertion is asynchronous; deassertion is seen at the next rising edge. Releasing reset mid-sequence starts from the all-zero state with no pending busy bits.

## Test plan
- Reset, then clear: hold reset = 0 after writing 0xBEEF to R3 → rd_data1 (addr 3) = 0, pc_out = 0, busy1 = 0, equal = 1, immediately without a clock edge.
- Bypass: BYPASS = 1, wr_en = 1, wr_addr = 2, wr_data = 0x1234, rd_addr1 = 2 → rd_data1 = 0x1234 in the same cycle. With BYPASS = 0 → old value, then 0x1234 after the edge.
- PC conflict: wr_en = 1, wr_addr = 7, wr_data = 0x0040, pc_wr_en = 1, pc_in = 0x0011 → after the edge, pc_out = 0x0040. Repeat with wr_en = 0 → pc_out = 0x0011.
- Equality: R1 = 0x00FF, R4 = 0x00FF, then R4 ← 0x00FE via a bypassed write → equal = 1, then equal = 0 in the write cycle.
- Scoreboard: issue R5 → busy = 1 next cycle. Writeback R5 with a same-cycle issue of R5 → stays busy. Writeback R5 alone → busy1 = 0 in that cycle (BYPASS = 1) and the bit clears after the edge.
- Flush: issue R1, R2, R3 on consecutive cycles, then flush with issue_en = 1 to R6 → all busy bits = 0 afterwards, including R6.
